// File: rtl/alarm_controller.sv
// Door alarm controller: arm/disarm button, exit/entry countdowns, siren.
// Optional ALARM_AUTO_REARM_EN: siren times out and re-arms.
//
// Ports:
//   clock_in     : system clock, all state on its rising edge
//   reset_in     : synchronous active-high reset
//   arm_btn_in   : debounced arm/disarm button level, 1 = pressed
//   door_open_in : debounced door sensor level, 1 = open
//   state_out    : 0 DISARMED, 1 ARMING, 2 ARMED, 3 ENTRY, 4 ALARM
//   armed_out    : high in ARMED, ENTRY, ALARM
//   warn_out     : high in ARMING, ENTRY
//   siren_out    : high in ALARM
module alarm_controller #(
  parameter int unsigned EXIT_DELAY_CYCLES  = 1_000_000,
  parameter int unsigned ENTRY_DELAY_CYCLES = 1_000_000,
  parameter int unsigned SIREN_CYCLES       = 5_000_000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       arm_btn_in,
  input  logic       door_open_in,
  output logic [2:0] state_out,
  output logic       armed_out,
  output logic       warn_out,
  output logic       siren_out
);

  localparam int unsigned MAX_A =
    (EXIT_DELAY_CYCLES > ENTRY_DELAY_CYCLES) ?
    EXIT_DELAY_CYCLES : ENTRY_DELAY_CYCLES;
  localparam int unsigned MAX_D =
    (MAX_A > SIREN_CYCLES) ? MAX_A : SIREN_CYCLES;
  localparam int unsigned CNT_W =
    (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CNT_W-1:0] EXIT_LOAD =
    CNT_W'(EXIT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD =
    CNT_W'(ENTRY_DELAY_CYCLES - 1);
`ifdef ALARM_AUTO_REARM_EN
  localparam logic [CNT_W-1:0] SIREN_LOAD =
    CNT_W'(SIREN_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press;
  logic             expired;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_DISARMED;
      cnt_q   <= '0;
      // Track the live button so a hold across reset is not a press.
      btn_q   <= arm_btn_in;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = arm_btn_in;
    press   = arm_btn_in & ~btn_q;
    expired = (cnt_q == '0);
    if (!expired) cnt_d = cnt_q - 1'b1;

    // Press wins over expiry and door events in every state.
    case (state_q)
      S_DISARMED: begin
        if (press) begin
          state_d = S_ARMING;
          cnt_d   = EXIT_LOAD;
        end
      end
      S_ARMING: begin
        if (press) begin
          state_d = S_DISARMED;
          cnt_d   = '0;
        end else if (expired) begin
          if (door_open_in) cnt_d = EXIT_LOAD;
          else state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (press) begin
          state_d = S_DISARMED;
          cnt_d   = '0;
        end else if (door_open_in) begin
          state_d = S_ENTRY;
          cnt_d   = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        if (press) begin
          state_d = S_DISARMED;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = S_ALARM;
`ifdef ALARM_AUTO_REARM_EN
          cnt_d   = SIREN_LOAD;
`else
          cnt_d   = '0;
`endif
        end
      end
      S_ALARM: begin
        if (press) begin
          state_d = S_DISARMED;
          cnt_d   = '0;
        end
`ifdef ALARM_AUTO_REARM_EN
        else if (expired) begin
          state_d = S_ARMED;
        end
`endif
      end
      default: begin
        state_d = S_DISARMED;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_out = state_q;
  assign armed_out = (state_q == S_ARMED) |
                     (state_q == S_ENTRY) |
                     (state_q == S_ALARM);
  assign warn_out  = (state_q == S_ARMING) |
                     (state_q == S_ENTRY);
  assign siren_out = (state_q == S_ALARM);

endmodule
